// File: rtl/misao_link_alu.sv
// misao_link_alu: nibble-serial ALU that processes N = 1<<link linked nibbles,
// one nibble per clock, with carry/borrow/shift bits chained between nibbles.
// Optional feature: define MISAO_LINK_ALU_ZFLAG_EN to add the registered
// 'zero' output (linked result == 0), updated together with result.
// Assumes NW >= 2.
module misao_link_alu #(
  parameter int NW = 4,
  parameter int NL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             neg,
  input  logic [1:0]       link,
  input  logic             carry_in,
  input  logic [NW*NL-1:0] a_in,
  input  logic [NW*NL-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [NW*NL-1:0] result,
`ifdef MISAO_LINK_ALU_ZFLAG_EN
  output logic             zero,
`endif
  output logic             carry_out
);

  localparam int W = NW * NL;
  // link can request at most 8 nibbles; clamp to what the datapath holds
  localparam int NMAX = (NL < 8) ? NL : 8;
  localparam logic [3:0] NMAX4 = 4'(NMAX);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADDC = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_SHF  = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   acc_q, acc_d;
  logic [2:0]     op_q;
  logic           neg_q;
  logic [3:0]     n_q;
  logic [3:0]     step_q, step_d;
  logic           cy_q, cy_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;
  logic           done_q, done_d;

  logic           load_s, step_en_s, last_s;
  logic [3:0]     n_raw_s, n_s;
  logic           cy_init_s;
  logic [3:0]     idx_s;
  int             lo_s;
  logic [NW-1:0]  an_s, bn_s, nib_s;
  logic [NW:0]    sum_s;

  assign busy      = (state_q == S_EXEC);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;

  // Decode linked nibble count and initial chain bit for the captured op
  always_comb begin
    n_raw_s = 4'd1 << link;
    if (n_raw_s > NMAX4) begin
      n_s = NMAX4;
    end else begin
      n_s = n_raw_s;
    end
    case (op)
      OP_INC:  cy_init_s = 1'b1;   // INC is a +/- 0 with the chain bit preset
      OP_SHF:  cy_init_s = 1'b0;   // shift fill bit
      default: cy_init_s = carry_in;
    endcase
  end

  // One nibble step: select nibble, compute its result and the next chain bit
  always_comb begin
    if ((op_q == OP_SHF) && neg_q) begin
      idx_s = n_q - 4'd1 - step_q;
    end else begin
      idx_s = step_q;
    end
    lo_s   = int'(idx_s) * NW;
    an_s   = a_q[lo_s +: NW];
    bn_s   = b_q[lo_s +: NW];
    nib_s  = an_s;
    sum_s  = '0;
    cy_d   = cy_q;
    case (op_q)
      OP_AND: nib_s = neg_q ? ~(an_s & bn_s) : (an_s & bn_s);
      OP_OR:  nib_s = neg_q ? ~(an_s | bn_s) : (an_s | bn_s);
      OP_XOR: nib_s = neg_q ? ~(an_s ^ bn_s) : (an_s ^ bn_s);
      OP_ADDC, OP_INC: begin
        if (neg_q) begin
          sum_s = {1'b0, an_s} - {1'b0, bn_s} - {{NW{1'b0}}, cy_q};
        end else begin
          sum_s = {1'b0, an_s} + {1'b0, bn_s} + {{NW{1'b0}}, cy_q};
        end
        nib_s = sum_s[NW-1:0];
        cy_d  = sum_s[NW];
      end
      OP_SHF: begin
        if (neg_q) begin
          nib_s = {cy_q, an_s[NW-1:1]};
          cy_d  = an_s[0];
        end else begin
          nib_s = {an_s[NW-2:0], cy_q};
          cy_d  = an_s[NW-1];
        end
      end
      default: nib_s = an_s;   // PASS
    endcase
    acc_d = acc_q;
    acc_d[lo_s +: NW] = nib_s;
    last_s = (step_q == (n_q - 4'd1));
    if (last_s) begin
      step_d = 4'd0;
    end else begin
      step_d = step_q + 4'd1;
    end
  end

  // FSM next-state and completion outputs
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    load_s      = 1'b0;
    step_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXEC;
          load_s  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        step_en_s = 1'b1;
        if (last_s) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          result_d    = acc_d;
          carry_out_d = cy_d;
        end else begin
          state_d = S_EXEC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  // Operand capture on accepted start; working registers advance per nibble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      op_q   <= 3'b000;
      neg_q  <= 1'b0;
      n_q    <= 4'd0;
      step_q <= 4'd0;
      cy_q   <= 1'b0;
    end else if (load_s) begin
      a_q    <= a_in;
      b_q    <= (op == OP_INC) ? '0 : b_in;
      acc_q  <= '0;   // clears result bits above the linked width
      op_q   <= op;
      neg_q  <= neg;
      n_q    <= n_s;
      step_q <= 4'd0;
      cy_q   <= cy_init_s;
    end else if (step_en_s) begin
      acc_q  <= acc_d;
      step_q <= step_d;
      cy_q   <= cy_d;
    end
  end

`ifdef MISAO_LINK_ALU_ZFLAG_EN
  logic zero_q, zero_d;

  assign zero = zero_q;

  // Zero flag follows the result written at completion
  always_comb begin
    if (done_d) begin
      zero_d = (acc_d == '0);
    end else begin
      zero_d = zero_q;
    end
  end

  // Zero flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end
`endif

endmodule

// File: doc/misao_link_alu.md
MISAO_LINK_ALU -- requirements
Module: misao_link_alu

Interface
REQ-001 Parameter NW, default 4: nibble width in bits.
REQ-002 Parameter NL, default 4: maximum linked nibbles; W = NW*NL.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  3  000 AND, 001 OR, 010 XOR, 011 ADDC, 100 INC, 101 SHF, 110/111 PASS (result=a).
REQ-007 neg  in  1  mode modifier, captured with start.
REQ-008 link  in  2  linked nibble count N = 1<<link; N > NL clamps to NL.
REQ-009 carry_in  in  1  ADDC carry/borrow in, captured with start.
REQ-010 a_in, b_in  in  W  operands, captured with start.
REQ-011 busy  out  1  high while in EXEC.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  W  registered result, held until next accepted start.
REQ-014 carry_out  out  1  registered carry/borrow/shift-out, held with result.

Function
REQ-015 FSM states: IDLE, EXEC; IDLE->EXEC on start; EXEC->IDLE after the N-th nibble step.
REQ-016 Start accepted at edge k; nibble steps on edges k+1..k+N, one nibble per edge; done=1 for exactly the cycle following edge k+N.
REQ-017 busy=1 from edge k to edge k+N; start while busy is ignored, with no effect on operands or count.
REQ-018 Start asserted in the done cycle (FSM in IDLE) is accepted.
REQ-019 Nibble index counter: ascending 0..N-1 for all ops except SHF with neg=1, which descends N-1..0.
REQ-020 AND/OR/XOR: per-nibble bitwise op; neg=1 inverts each result bit; carry_out = captured carry_in.
REQ-021 ADDC neg=0: a+b+carry_in over N nibbles, internal carry chained nibble to nibble; carry_out = final carry.
REQ-022 ADDC neg=1: a-b-carry_in, borrow chained; carry_out = final borrow.
REQ-023 INC: neg=0 adds 1, neg=1 subtracts 1 at nibble 0; carry_in ignored; carry_out = final carry/borrow.
REQ-024 SHF neg=0: left shift of N*NW-bit word; bit 0 filled 0; carry_out = old MSB of linked word.
REQ-025 SHF neg=1: right shift; MSB of linked word filled 0; carry_out = old bit 0.
REQ-026 Result bits at or above N*NW are 0 after completion; operand bits above N*NW are ignored.
REQ-027 PASS: result = a within linked width; carry_out = carry_in.
REQ-028 result and carry_out update only at completion; intermediate steps use internal registers.

Reset
REQ-029 rst forces IDLE, busy=0, done=0, result=0, carry_out=0, counter=0, zero=1 (if present), at any time including mid-EXEC.
REQ-030 An aborted operation never produces done.

Configuration
REQ-031 Macro MISAO_LINK_ALU_ZFLAG_EN defined: output port zero (1 bit) exists; registered with done, 1 when linked result == 0, held with result.
REQ-032 Macro absent: no zero port and no zero-detect logic; all other behaviour is identical.

Verification (NW=4, NL=4)
REQ-033 ADDC neg=0, link=10, a=0xFFFF, b=0x0001, cin=0 -> done 4 edges after start, result=0x0000, carry_out=1, zero=1.
REQ-034 ADDC neg=1, link=00, a=0x0003, b=0x0005, cin=0 -> done after 1 edge, result=0x000E, carry_out=1.
REQ-035 SHF neg=1, link=01, a=0x0013 -> result=0x0009, carry_out=1; SHF neg=0, link=01, a=0x0080 -> result=0x0000, carry_out=1.
REQ-036 XOR neg=1, link=01, a=0x00F0, b=0x0FF0 -> result=0x00FF (upper bits cleared), carry_out=carry_in.
REQ-037 INC link=10, a=0x1234; pulse start again mid-EXEC with a=0xFFFF -> result=0x1235, single done; second start ignored.
REQ-038 ADDC link=10 then rst at step 2 -> busy=0, result=0, no done; a new start then completes normally.
